// File: rtl/adc_pwr_pkg.sv
// Shared state encoding, command codes and helpers for the ADC power/calibration sequencer.
package adc_pwr_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_OFF       = 4'd0,
        ST_ADC_WARM  = 4'd1,
        ST_ANA_WARM  = 4'd2,
        ST_INIT_WR   = 4'd3,
        ST_INIT_WARM = 4'd4,
        ST_CAL_REQ   = 4'd5,
        ST_CAL       = 4'd6,
        ST_DES_EN    = 4'd7,
        ST_SAMPLING  = 4'd8,
        ST_DIS_IDLE  = 4'd9,
        ST_IDLE      = 4'd10,
        ST_WAKE      = 4'd11,
        ST_DIS_CAL   = 4'd12,
        ST_SHUTDOWN  = 4'd13
    } state_e;

    localparam logic [7:0] CMD_ON    = 8'h4F;  // "O"
    localparam logic [7:0] CMD_OFF   = 8'h6F;  // "o"
    localparam logic [7:0] CMD_SLEEP = 8'h53;  // "S"
    localparam logic [7:0] CMD_WAKE  = 8'h57;  // "W"
    localparam logic [7:0] CMD_CAL   = 8'h43;  // "C"

    // Where each register-write state goes once the serial writer reports completion
    function automatic state_e reg_done_target(input state_e s);
        case (s)
            ST_INIT_WR:  reg_done_target = ST_INIT_WARM;
            ST_DES_EN:   reg_done_target = ST_SAMPLING;
            ST_DIS_IDLE: reg_done_target = ST_IDLE;
            ST_DIS_CAL:  reg_done_target = ST_CAL_REQ;
            default:     reg_done_target = ST_OFF;
        endcase
    endfunction

endpackage

// File: rtl/adc_seq_timer.sv
// Up-counter with synchronous clear and a combinational terminal-count compare.
module adc_seq_timer #(
    parameter int W = 24
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         i_clear,
    input  logic [W-1:0] i_terminal,
    output logic         o_hit
);

    logic [W-1:0] r_count;

    // Count up every cycle; restart from zero on reset or clear
    always_ff @(posedge Clock) begin
        if (Reset || i_clear) begin
            r_count <= {W{1'b0}};
        end else begin
            r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign o_hit = (r_count == i_terminal);

endmodule

// File: rtl/adc_power_sequencer.sv
// ADC rail / DES / calibration sequencer with timeouts, retries and a sticky fault.
// Optional periodic recalibration in SAMPLING when ADC_PWR_SEQ_AUTO_RECAL_EN is defined.
module adc_power_sequencer
    import adc_pwr_pkg::*;
#(
    parameter int TIMER_W         = 24,
    parameter int ADC_WARM_CYC    = 256,
    parameter int ANALOG_WARM_CYC = 1048576,
    parameter int INIT_WARM_CYC   = 128,
    parameter int WAKE_CYC        = 128,
    parameter int SHUTDN_CYC      = 256,
    parameter int REG_TIMEOUT_CYC = 65536,
    parameter int CAL_TIMEOUT_CYC = 4194304,
    parameter int CAL_RETRIES     = 2
`ifdef ADC_PWR_SEQ_AUTO_RECAL_EN
    , parameter int RECAL_PERIOD_CYC = 2**23
`endif
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       CmdValid,
    input  logic [7:0] Cmd,
    input  logic       OutToADCEnable,
    input  logic       Sleep,
    input  logic       WakeUp,
    input  logic       CalRunning,
    input  logic       RegWriteDone,
    output logic       ADCPower,
    output logic       AnalogPower,
    output logic       PinEnable,
    output logic       RegInitReq,
    output logic       DesEnableReq,
    output logic       DesDisableReq,
    output logic [3:0] State,
    output logic       Sampling,
    output logic       Fault
);

    state_e             r_state;
    state_e             w_next;
    logic [2:0]         r_retries;
    logic [2:0]         w_retries_next;
    logic               r_fault;
    logic               w_fault_next;
    logic [TIMER_W-1:0] w_terminal;
    logic               w_hit;
    logic               w_recal_hit;
    logic               w_cal_event;
    logic               r_adc_power;
    logic               r_analog_power;
    logic               r_reg_init_req;
    logic               r_des_enable_req;
    logic               r_des_disable_req;
    logic               r_sampling;

    wire w_cmd_on    = CmdValid && (Cmd == CMD_ON);
    wire w_cmd_off   = CmdValid && (Cmd == CMD_OFF);
    wire w_cmd_sleep = CmdValid && (Cmd == CMD_SLEEP);
    wire w_cmd_wake  = CmdValid && (Cmd == CMD_WAKE);
    wire w_cmd_cal   = CmdValid && (Cmd == CMD_CAL);

    assign w_cal_event = (r_state == ST_CAL_REQ) ? CalRunning : !CalRunning;

    // Per-state terminal count for the shared dwell / timeout timer
    always_comb begin
        w_terminal = {TIMER_W{1'b1}};
        case (r_state)
            ST_ADC_WARM:  w_terminal = TIMER_W'(ADC_WARM_CYC - 1);
            ST_ANA_WARM:  w_terminal = TIMER_W'(ANALOG_WARM_CYC - 1);
            ST_INIT_WARM: w_terminal = TIMER_W'(INIT_WARM_CYC - 1);
            ST_WAKE:      w_terminal = TIMER_W'(WAKE_CYC - 1);
            ST_SHUTDOWN:  w_terminal = TIMER_W'(SHUTDN_CYC - 1);
            ST_INIT_WR, ST_DES_EN, ST_DIS_IDLE, ST_DIS_CAL:
                          w_terminal = TIMER_W'(REG_TIMEOUT_CYC - 1);
            ST_CAL_REQ, ST_CAL:
                          w_terminal = TIMER_W'(CAL_TIMEOUT_CYC - 1);
            default:      w_terminal = {TIMER_W{1'b1}};
        endcase
    end

    adc_seq_timer #(.W(TIMER_W)) u_state_timer (
        .Clock      (Clock),
        .Reset      (Reset),
        .i_clear    (w_next != r_state),
        .i_terminal (w_terminal),
        .o_hit      (w_hit)
    );

`ifdef ADC_PWR_SEQ_AUTO_RECAL_EN
    logic w_recal_tick;

    adc_seq_timer #(.W(TIMER_W)) u_recal_timer (
        .Clock      (Clock),
        .Reset      (Reset),
        .i_clear    (r_state != ST_SAMPLING),
        .i_terminal (TIMER_W'(RECAL_PERIOD_CYC - 1)),
        .o_hit      (w_recal_tick)
    );

    assign w_recal_hit = w_recal_tick && (r_state == ST_SAMPLING);
`else
    assign w_recal_hit = 1'b0;
`endif

    // Next state, retry count and fault; global shutdown outranks every other event
    always_comb begin
        w_next         = r_state;
        w_retries_next = r_retries;
        w_fault_next   = r_fault;
        if ((r_state != ST_OFF) && (r_state != ST_SHUTDOWN) && (w_cmd_off || !OutToADCEnable)) begin
            w_next = ST_SHUTDOWN;
        end else begin
            case (r_state)
                ST_OFF: begin
                    if (w_cmd_on) begin
                        w_next       = ST_ADC_WARM;
                        w_fault_next = 1'b0;
                    end else begin
                        w_next = ST_OFF;
                    end
                end
                ST_ADC_WARM:  w_next = w_hit ? ST_ANA_WARM : ST_ADC_WARM;
                ST_ANA_WARM:  w_next = w_hit ? ST_INIT_WR : ST_ANA_WARM;
                ST_WAKE:      w_next = w_hit ? ST_DES_EN : ST_WAKE;
                ST_SHUTDOWN:  w_next = w_hit ? ST_OFF : ST_SHUTDOWN;
                ST_INIT_WARM: begin
                    if (w_hit) begin
                        w_next         = ST_CAL_REQ;
                        w_retries_next = 3'd0;
                    end else begin
                        w_next = ST_INIT_WARM;
                    end
                end
                ST_INIT_WR, ST_DES_EN, ST_DIS_IDLE, ST_DIS_CAL: begin
                    if (RegWriteDone) begin
                        w_next         = reg_done_target(r_state);
                        w_retries_next = (r_state == ST_DES_EN) ? 3'd0 : r_retries;
                    end else if (w_hit) begin
                        w_next       = ST_SHUTDOWN;
                        w_fault_next = 1'b1;
                    end else begin
                        w_next = r_state;
                    end
                end
                ST_CAL_REQ, ST_CAL: begin
                    if (w_cal_event) begin
                        w_next = (r_state == ST_CAL_REQ) ? ST_CAL : ST_DES_EN;
                    end else if (w_hit && (r_retries < 3'(CAL_RETRIES))) begin
                        w_next         = ST_DIS_CAL;
                        w_retries_next = r_retries + 3'd1;
                    end else if (w_hit) begin
                        w_next       = ST_SHUTDOWN;
                        w_fault_next = 1'b1;
                    end else begin
                        w_next = r_state;
                    end
                end
                ST_SAMPLING: begin
                    if (w_cmd_sleep || Sleep) begin
                        w_next = ST_DIS_IDLE;
                    end else if (w_cmd_cal || w_recal_hit) begin
                        w_next = ST_DIS_CAL;
                    end else begin
                        w_next = ST_SAMPLING;
                    end
                end
                ST_IDLE:  w_next = (w_cmd_wake || WakeUp) ? ST_WAKE : ST_IDLE;
                default:  w_next = ST_OFF;
            endcase
        end
    end

    // State, bookkeeping and outputs registered from the next-state decode
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state           <= ST_OFF;
            r_retries         <= 3'd0;
            r_fault           <= 1'b0;
            r_adc_power       <= 1'b0;
            r_analog_power    <= 1'b0;
            r_reg_init_req    <= 1'b0;
            r_des_enable_req  <= 1'b0;
            r_des_disable_req <= 1'b0;
            r_sampling        <= 1'b0;
        end else begin
            r_state           <= w_next;
            r_retries         <= w_retries_next;
            r_fault           <= w_fault_next;
            r_adc_power       <= (w_next != ST_OFF);
            r_analog_power    <= OutToADCEnable && (w_next != ST_OFF) &&
                                 (w_next != ST_ADC_WARM) && (w_next != ST_SHUTDOWN);
            r_reg_init_req    <= (w_next == ST_INIT_WR);
            r_des_enable_req  <= (w_next == ST_DES_EN);
            r_des_disable_req <= (w_next == ST_DIS_IDLE) || (w_next == ST_DIS_CAL);
            r_sampling        <= (w_next == ST_SAMPLING);
        end
    end

    assign ADCPower      = r_adc_power;
    assign AnalogPower   = r_analog_power;
    assign PinEnable     = r_analog_power;
    assign RegInitReq    = r_reg_init_req;
    assign DesEnableReq  = r_des_enable_req;
    assign DesDisableReq = r_des_disable_req;
    assign State         = r_state;
    assign Sampling      = r_sampling;
    assign Fault         = r_fault;

endmodule
